// File: rtl/alu_share_if.sv
// alu_share_if: bundles the request, ALU and response signals of alu_share_arbiter.
//   req_*  : per-requester operation channel, requester i in element [i]
//   alu_*  : drive/return signals of the shared cv32e40p ALU
//   rsp_*  : registered response channel tagged with the requester ID
// Modports: slave  = the arbiter
//           master = the environment (requesters, ALU and response sink)
interface alu_share_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3,
  parameter int OP_W    = 7
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][OP_W-1:0] req_operator;
  logic [NUM_REQ-1:0][31:0]     req_operand_a;
  logic [NUM_REQ-1:0][31:0]     req_operand_b;
  logic [NUM_REQ-1:0][31:0]     req_operand_c;
  logic [NUM_REQ-1:0][1:0]      req_vector_mode;

  logic                         alu_enable;
  logic [OP_W-1:0]              alu_operator;
  logic [31:0]                  alu_operand_a;
  logic [31:0]                  alu_operand_b;
  logic [31:0]                  alu_operand_c;
  logic [1:0]                   alu_vector_mode;
  logic                         alu_ex_ready;
  logic [31:0]                  alu_result;
  logic                         alu_comparison_result;
  logic                         alu_ready;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [31:0]                  rsp_result;
  logic                         rsp_cmp;
  logic                         rsp_err;

  modport slave (
    input  req_valid, req_operator, req_operand_a, req_operand_b, req_operand_c,
           req_vector_mode, alu_result, alu_comparison_result, alu_ready, rsp_ready,
    output req_ready, alu_enable, alu_operator, alu_operand_a, alu_operand_b,
           alu_operand_c, alu_vector_mode, alu_ex_ready, rsp_valid, rsp_id,
           rsp_result, rsp_cmp, rsp_err
  );

  modport master (
    output req_valid, req_operator, req_operand_a, req_operand_b, req_operand_c,
           req_vector_mode, alu_result, alu_comparison_result, alu_ready, rsp_ready,
    input  req_ready, alu_enable, alu_operator, alu_operand_a, alu_operand_b,
           alu_operand_c, alu_vector_mode, alu_ex_ready, rsp_valid, rsp_id,
           rsp_result, rsp_cmp, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between NUM_REQ requesters.
// Round-robin grant in IDLE, one operation in flight in EXEC (until alu_ready
// or TIMEOUT cycles), result held on a valid/ready response in RESP.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    alu_share_if.slave (request, ALU and response channels)
//   busy   high whenever the arbiter is not IDLE
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3,
  parameter int OP_W    = 7,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_share_if.slave  bus,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d, c_q, c_d;
  logic [1:0]      vm_q, vm_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_cmp_q, rsp_cmp_d;
  logic            rsp_err_q, rsp_err_d;

  // Round-robin: the lowest valid index >= rr_ptr wins; if there is none the
  // search wraps, so the lowest valid index overall wins.
  logic            any_hi, found, grant;
  logic [ID_W-1:0] win_hi, win_lo, winner;

  always_comb begin
    any_hi = 1'b0;
    found  = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found  = 1'b1;
        win_lo = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          any_hi = 1'b1;
          win_hi = ID_W'(i);
        end
      end
    end
    winner = any_hi ? win_hi : win_lo;
  end

  // rst_n gates the grant so nothing is accepted while reset is held.
  assign grant = rst_n && (state_q == IDLE) && found;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = grant && (winner == ID_W'(i));
    end
  end

  // Winner payload mux.
  logic [OP_W-1:0] sel_op;
  logic [31:0]     sel_a, sel_b, sel_c;
  logic [1:0]      sel_vm;

  always_comb begin
    sel_op = bus.req_operator[0];
    sel_a  = bus.req_operand_a[0];
    sel_b  = bus.req_operand_b[0];
    sel_c  = bus.req_operand_c[0];
    sel_vm = bus.req_vector_mode[0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_op = bus.req_operator[i];
        sel_a  = bus.req_operand_a[i];
        sel_b  = bus.req_operand_b[i];
        sel_c  = bus.req_operand_c[i];
        sel_vm = bus.req_vector_mode[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    vm_d         = vm_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_cmp_d    = rsp_cmp_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          op_d     = sel_op;
          a_d      = sel_a;
          b_d      = sel_b;
          c_d      = sel_c;
          vm_d     = sel_vm;
          id_d     = winner;
          rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          cnt_d    = '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 8'd1;
        // A result arriving in the last allowed cycle still counts as success.
        if (bus.alu_ready) begin
          rsp_result_d = bus.alu_result;
          rsp_cmp_d    = bus.alu_comparison_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_cmp_d    = 1'b0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      vm_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cmp_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      vm_q         <= vm_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cmp_q    <= rsp_cmp_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // ALU inputs come straight from the latched operation so they hold still
  // outside EXEC.
  assign bus.alu_enable      = (state_q == EXEC);
  assign bus.alu_ex_ready    = (state_q == EXEC);
  assign bus.alu_operator    = op_q;
  assign bus.alu_operand_a   = a_q;
  assign bus.alu_operand_b   = b_q;
  assign bus.alu_operand_c   = c_q;
  assign bus.alu_vector_mode = vm_q;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cmp    = rsp_cmp_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one cv32e40p ALU instance between NUM_REQ requesters, e.g. the core EX stage and a debug/test operand port.
- Round-robin arbitrates incoming operation requests and drives the ALU input signals with the granted operation.
- Waits for the ALU ready output, which covers multi-cycle divide and remainder operations.
- Returns the result on a registered valid/ready response channel tagged with the requester ID, and guards every operation with a timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 3, width of the requester ID tag; must satisfy 2**ID_W >= NUM_REQ.
- OP_W, 7, width of the ALU operator field (alu_opcode_e).
- TIMEOUT, 64, maximum number of EXEC cycles before the operation is aborted; legal range 2..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester grant / accept
- req_operator  in  NUM_REQ*OP_W  packed operators; requester i occupies slice [i*OP_W +: OP_W]
- req_operand_a  in  NUM_REQ*32  packed operand A
- req_operand_b  in  NUM_REQ*32  packed operand B
- req_operand_c  in  NUM_REQ*32  packed operand C
- req_vector_mode  in  NUM_REQ*2  packed vector mode
- alu_enable  out  1  ALU enable
- alu_operator  out  OP_W  to the ALU
- alu_operand_a  out  32  to the ALU
- alu_operand_b  out  32  to the ALU
- alu_operand_c  out  32  to the ALU
- alu_vector_mode  out  2  to the ALU
- alu_ex_ready  out  1  result-consumed indication to the ALU
- alu_result  in  32  from the ALU
- alu_comparison_result  in  1  from the ALU
- alu_ready  in  1  ALU result valid / divider done
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  ID of the requester that owns the response
- rsp_result  out  32  result
- rsp_cmp  out  1  comparison result
- rsp_err  out  1  1 = operation timed out, result forced to 0
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - state = IDLE, rr_ptr = 0, timeout counter = 0.
  - All rsp_* outputs = 0.
  - alu_enable = 0, alu_ex_ready = 0.
  - Latched operation registers = 0.
  - req_ready = 0 while rst_n = 0.
- Reset mid-operation: the in-flight operation is dropped. No response is issued and no req_ready is raised.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first requester with req_valid set, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally in the same cycle; all other req_ready bits = 0.
  - On the clock edge: latch the winner's operator, operands, vector mode and ID; set rr_ptr = (winner+1) mod NUM_REQ; go to EXEC.
  - No req_valid set: stay in IDLE; rr_ptr unchanged.
  - req_ready is 0 in EXEC and RESP. There is only one operation in flight.
- EXEC:
  - alu_enable = 1, ALU inputs driven from the latched registers, alu_ex_ready = 1.
  - The timeout counter increments every EXEC cycle.
  - alu_ready = 1: capture alu_result and alu_comparison_result into rsp_result and rsp_cmp, rsp_err = 0, go to RESP.
  - Counter reaches TIMEOUT-1 with alu_ready still 0: rsp_result = 0, rsp_cmp = 0, rsp_err = 1, go to RESP.
  - If alu_ready = 1 and the timeout condition occur in the same cycle, alu_ready wins.
- Outside EXEC: alu_enable = 0, alu_ex_ready = 0. ALU operand outputs hold their last latched value so they do not toggle.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_result, rsp_cmp and rsp_err are held stable until rsp_ready = 1.
  - On rsp_valid && rsp_ready: rsp_valid falls on the next edge, go to IDLE, timeout counter cleared.
  - A new grant can happen at the earliest in the cycle after the handshake.
- Latency for a single-cycle op:
  - Grant in cycle T.
  - EXEC with alu_ready = 1 in cycle T+1.
  - rsp_valid = 1 in cycle T+2.
- Throughput with rsp_ready held at 1: one op per 3 cycles.
- Divider ops: latency = ALU cycles + 2.
- Requester rule: a requester must hold req_valid and its payload until it sees req_ready. The arbiter does not check this.

Test Plan:
- Reset, then req0 ADD a=5 b=7 -> req_ready[0] in cycle T; alu_enable only in T+1; rsp_valid in T+2 with rsp_result=12, rsp_id=0, rsp_err=0.
- req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rr_ptr wraps; each grant exactly 3 cycles apart.
- req1 DIV a=100 b=7, ALU model raises alu_ready after 34 cycles -> alu_enable high for 34 cycles; rsp_result=14; alu_ex_ready high throughout EXEC.
- ALU model never raises alu_ready, TIMEOUT=64 -> exactly 64 EXEC cycles; rsp_err=1, rsp_result=0; next request served normally.
- rsp_ready held 0 for 10 cycles with req0 pending -> rsp fields stable for all 10 cycles; req_ready stays 0; grant of req0 occurs the cycle after rsp_ready=1.
- rst_n=0 asserted during the 5th EXEC cycle of a DIV -> next cycle: state IDLE, rsp_valid=0, alu_enable=0; no response emitted for the aborted op.
